// File: rtl/axi4_wr_burst_chunker.sv
// axi4_wr_burst_chunker: splits AXI4 write bursts into MemWr-sized chunks, split at 4KB, B returned after the last chunk
module axi4_wr_burst_chunker #(
  parameter int          ID_WIDTH        = 4,
  parameter int          ADDR_WIDTH      = 32,
  parameter int          DATA_WIDTH      = 256,
  parameter int          CHUNK_MAX_BEATS = 4,
  parameter int          AW_FIFO_DEPTH   = 4,
  parameter logic [15:0] DEVICE_BDF      = 16'h0200
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  s_awvalid,
  output logic                                  s_awready,
  input  logic [ID_WIDTH-1:0]                   s_awid,
  input  logic [ADDR_WIDTH-1:0]                 s_awaddr,
  input  logic [7:0]                            s_awlen,
  input  logic                                  s_wvalid,
  output logic                                  s_wready,
  input  logic [DATA_WIDTH-1:0]                 s_wdata,
  input  logic                                  s_wlast,
  output logic                                  s_bvalid,
  input  logic                                  s_bready,
  output logic [ID_WIDTH-1:0]                   s_bid,
  output logic [1:0]                            s_bresp,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [ADDR_WIDTH-1:0]                 out_addr,
  output logic [9:0]                            out_length,
  output logic [$clog2(CHUNK_MAX_BEATS):0]      out_beats,
  output logic [15:0]                           out_bdf,
  output logic                                  out_is_memwrite,
  output logic [DATA_WIDTH*CHUNK_MAX_BEATS-1:0] out_wdata
);
  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int OFF = $clog2(BEAT_BYTES);
  localparam int CW = $clog2(CHUNK_MAX_BEATS) + 1;
  localparam int IW = (CHUNK_MAX_BEATS > 1) ? $clog2(CHUNK_MAX_BEATS) : 1;
  localparam int PW = $clog2(AW_FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, COLLECT, EMIT, RESP} state_t;

  if (CHUNK_MAX_BEATS * BEAT_BYTES > 4096) begin : g_size_chk
    $error("CHUNK_MAX_BEATS*BEAT_BYTES must not exceed 4096");
  end

  logic [ID_WIDTH-1:0]   fid_q   [AW_FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] faddr_q [AW_FIFO_DEPTH];
  logic [7:0]            flen_q  [AW_FIFO_DEPTH];
  logic [PW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  full, empty, push;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [8:0]            bl_q, bl_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] buf_q [CHUNK_MAX_BEATS];
  logic [DATA_WIDTH-1:0] buf_d [CHUNK_MAX_BEATS];
  logic [11:0]           end_off;
  logic                  last_beat, close;

  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign empty = wr_ptr_q == rd_ptr_q;
  assign s_awready = rst_n && !full;
  assign push = s_awvalid && s_awready;

  assign cnt_inc   = cnt_q + CW'(1);
  assign end_off   = cur_addr_q[11:0] + (12'(cnt_inc) << OFF);
  assign last_beat = bl_q == 9'd1;
  assign close     = (cnt_inc == CW'(CHUNK_MAX_BEATS)) || last_beat || (end_off == 12'h0);

  assign s_wready        = state_q == COLLECT;
  assign s_bvalid        = state_q == RESP;
  assign out_valid       = state_q == EMIT;
  assign s_bid           = bid_q;
  assign s_bresp         = {err_q, 1'b0};
  assign out_addr        = cur_addr_q;
  assign out_beats       = cnt_q;
  assign out_length      = 10'(32'(cnt_q) * (DATA_WIDTH / 32));
  assign out_bdf         = DEVICE_BDF;
  assign out_is_memwrite = 1'b1;

  for (genvar k = 0; k < CHUNK_MAX_BEATS; k++) begin : g_lane
    assign out_wdata[k*DATA_WIDTH +: DATA_WIDTH] = buf_q[k];
  end

  // AW queue storage, address aligned down to the beat size on capture
  always_ff @(posedge clk)
    if (push) begin
      fid_q[wr_ptr_q[PW-1:0]]   <= s_awid;
      faddr_q[wr_ptr_q[PW-1:0]] <= s_awaddr & ~ADDR_WIDTH'(BEAT_BYTES - 1);
      flen_q[wr_ptr_q[PW-1:0]]  <= s_awlen;
    end

  // burst FSM: pop AW, gather beats into a chunk, emit it, respond once the burst is done
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    bl_d       = bl_q;
    cnt_d      = cnt_q;
    bid_d      = bid_q;
    err_d      = err_q;
    buf_d      = buf_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q + {{PW{1'b0}}, push};
    case (state_q)
      IDLE: if (!empty) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        cur_addr_d = faddr_q[rd_ptr_q[PW-1:0]];
        bl_d       = {1'b0, flen_q[rd_ptr_q[PW-1:0]]} + 9'd1;
        bid_d      = fid_q[rd_ptr_q[PW-1:0]];
        err_d      = 1'b0;
        cnt_d      = '0;
        buf_d      = '{default: '0};
        state_d    = COLLECT;
      end
      COLLECT: if (s_wvalid) begin
        buf_d[cnt_q[IW-1:0]] = s_wdata;
        cnt_d   = cnt_inc;
        bl_d    = bl_q - 9'd1;
        err_d   = err_q || (s_wlast != last_beat);
        state_d = close ? EMIT : COLLECT;
      end
      EMIT: if (out_ready) begin
        cur_addr_d = cur_addr_q + (ADDR_WIDTH'(cnt_q) << OFF);
        cnt_d      = '0;
        buf_d      = '{default: '0};
        state_d    = (bl_q == 9'd0) ? RESP : COLLECT;
      end
      RESP: state_d = s_bready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  // state registers; reset drops any burst in flight without a response
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      bl_q       <= '0;
      cnt_q      <= '0;
      bid_q      <= '0;
      err_q      <= 1'b0;
      buf_q      <= '{default: '0};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      bl_q       <= bl_d;
      cnt_q      <= cnt_d;
      bid_q      <= bid_d;
      err_q      <= err_d;
      buf_q      <= buf_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
endmodule

// File: tb/tb_axi4_wr_burst_chunker.sv
// tb_axi4_wr_burst_chunker: scoreboard bench for the write burst chunker
module tb_axi4_wr_burst_chunker;
  localparam int DW = 256;
  localparam int NB = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_awvalid, s_awready;
  logic [3:0]        s_awid;
  logic [31:0]       s_awaddr;
  logic [7:0]        s_awlen;
  logic              s_wvalid, s_wready, s_wlast;
  logic [DW-1:0]     s_wdata;
  logic              s_bvalid, s_bready;
  logic [3:0]        s_bid;
  logic [1:0]        s_bresp;
  logic              out_valid, out_ready;
  logic [31:0]       out_addr;
  logic [9:0]        out_length;
  logic [2:0]        out_beats;
  logic [15:0]       out_bdf;
  logic              out_is_memwrite;
  logic [DW*NB-1:0]  out_wdata;

  always #5 clk = ~clk;

  axi4_wr_burst_chunker dut (
    .clk(clk), .rst_n(rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_length(out_length),
    .out_beats(out_beats), .out_bdf(out_bdf), .out_is_memwrite(out_is_memwrite), .out_wdata(out_wdata)
  );

  typedef struct packed {logic [31:0] a; logic [9:0] l; logic [2:0] b; logic [DW*NB-1:0] d;} chunk_t;
  typedef struct packed {logic [3:0] id; logic [1:0] r;} bresp_t;
  typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;

  chunk_t exp_c[$];
  bresp_t exp_b[$];
  beat_t  wq[$];
  int     checks = 0;
  int     fails = 0;
  int     n_chunks = 0;
  logic   w_en = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", tag, act, want);
    end
  endtask

  // reference model: expected chunks, W beats and B for one burst
  task automatic prep(input logic [3:0] id, input logic [31:0] addr, input int len, input int bad);
    chunk_t c;
    beat_t bt;
    int n;
    c = '0;
    c.a = addr & ~32'h1F;
    n = 0;
    for (int i = 0; i <= len; i++) begin
      for (int k = 0; k < DW / 32; k++) bt.d[k*32 +: 32] = $urandom;
      bt.l = (bad >= 0) ? (i == bad) : (i == len);
      wq.push_back(bt);
      c.d[n*DW +: DW] = bt.d;
      n++;
      if (n == NB || i == len || ((c.a + 32'(n * 32)) & 32'hFFF) == 0) begin
        logic [31:0] nxt;
        nxt = c.a + 32'(n * 32);
        c.b = 3'(n);
        c.l = 10'(n * 8);
        exp_c.push_back(c);
        c = '0;
        c.a = nxt;
        n = 0;
      end
    end
    exp_b.push_back({id, (bad >= 0) ? 2'b10 : 2'b00});
  endtask

  task automatic aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    @(posedge clk); #1;
    s_awvalid = 1'b1; s_awid = id; s_awaddr = addr; s_awlen = len;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_awready) begin
        @(posedge clk); #1;
        s_awvalid = 1'b0;
        return;
      end
    end
    chk("aw_timeout", 0, 1);
    s_awvalid = 1'b0;
  endtask

  task automatic burst(input logic [3:0] id, input logic [31:0] addr, input int len, input int bad);
    prep(id, addr, len, bad);
    aw(id, addr, 8'(len));
  endtask

  task automatic drain();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (exp_c.size() == 0 && exp_b.size() == 0 && wq.size() == 0) return;
    end
    chk("drain_timeout", 0, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_awready"}, s_awready, 0);
    chk({tag, "_wready"}, s_wready, 0);
    chk({tag, "_bvalid"}, s_bvalid, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_bid"}, s_bid, 0);
    chk({tag, "_bresp"}, s_bresp, 0);
    chk({tag, "_out_addr"}, out_addr, 0);
    chk({tag, "_out_length"}, out_length, 0);
    chk({tag, "_out_beats"}, out_beats, 0);
    for (int k = 0; k < NB; k++) chk($sformatf("%s_lane%0d", tag, k), out_wdata[k*DW +: DW], 0);
  endtask

  // W channel driver fed from the beat queue
  initial begin
    logic fire;
    s_wvalid = 1'b0; s_wdata = '0; s_wlast = 1'b0;
    forever begin
      @(negedge clk);
      fire = s_wvalid && s_wready;
      @(posedge clk); #1;
      if (fire) void'(wq.pop_front());
      s_wvalid = w_en && wq.size() > 0;
      s_wdata  = (wq.size() > 0) ? wq[0].d : '0;
      s_wlast  = (wq.size() > 0) && wq[0].l;
    end
  end

  // output monitor: compare each accepted chunk and response against the scoreboard
  always @(negedge clk) begin
    chunk_t mc;
    bresp_t mb;
    if (rst_n && out_valid && out_ready) begin
      n_chunks++;
      if (exp_c.size() == 0) chk("chunk_extra", 1, 0);
      else begin
        mc = exp_c.pop_front();
        chk("out_addr", out_addr, mc.a);
        chk("out_length", out_length, mc.l);
        chk("out_beats", out_beats, mc.b);
        chk("out_bdf", out_bdf, 16'h0200);
        chk("out_is_memwrite", out_is_memwrite, 1);
        for (int k = 0; k < NB; k++) chk($sformatf("lane%0d", k), out_wdata[k*DW +: DW], mc.d[k*DW +: DW]);
      end
    end
    if (rst_n && s_bvalid && s_bready) begin
      if (exp_b.size() == 0) chk("b_extra", 1, 0);
      else begin
        mb = exp_b.pop_front();
        chk("bid", s_bid, mb.id);
        chk("bresp", s_bresp, mb.r);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]      sa;
    logic [2:0]       sb;
    logic [DW*NB-1:0] sw;
    int n0, nb;
    s_awvalid = 1'b0; s_awid = '0; s_awaddr = '0; s_awlen = '0;
    s_bready = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check_zero("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    w_en = 1'b1; out_ready = 1'b1; s_bready = 1'b1;

    burst(4'd1, 32'h1000, 7, -1);
    drain();
    burst(4'd2, 32'h2000, 5, -1);
    drain();
    n0 = n_chunks;
    burst(4'd3, 32'h0FC0, 3, -1);
    drain();
    chk("t3_nchunks", 32'(n_chunks - n0), 2);

    out_ready = 1'b0;
    burst(4'd4, 32'h3000, 7, -1);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    chk("t4_wait", out_valid, 1);
    sa = out_addr; sb = out_beats; sw = out_wdata;
    chk("t4_beats", sb, 4);
    chk("t4_addr", sa, 32'h3000);
    repeat (10) begin
      @(negedge clk);
      chk("t4_wready", s_wready, 0);
      chk("t4_valid", out_valid, 1);
      chk("t4_addr_hold", out_addr, sa);
      chk("t4_beats_hold", out_beats, sb);
      for (int k = 0; k < NB; k++) chk("t4_lane_hold", out_wdata[k*DW +: DW], sw[k*DW +: DW]);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    @(posedge clk); #1;
    w_en = 1'b0; s_bready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      prep(4'(8 + i), 32'h8000 + 32'(i * 'h100), 1, -1);
      @(posedge clk); #1;
      s_awvalid = 1'b1; s_awid = 4'(8 + i); s_awaddr = 32'h8000 + 32'(i * 'h100); s_awlen = 8'd1;
      @(negedge clk);
      chk("t5_awready", s_awready, 1);
    end
    prep(4'd13, 32'h8800, 1, -1);
    @(posedge clk); #1;
    s_awid = 4'd13; s_awaddr = 32'h8800; s_awlen = 8'd1;
    repeat (5) begin
      @(negedge clk);
      chk("t5_full", s_awready, 0);
    end
    @(posedge clk); #1;
    w_en = 1'b1; s_bready = 1'b1;
    for (int i = 0; i < 200 && !s_awready; i++) @(negedge clk);
    chk("t5_unblock", s_awready, 1);
    chk("t5_first_b_done", 32'(exp_b.size()), 5);
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    drain();

    burst(4'd6, 32'h4000, 3, 2);
    drain();
    aw(4'd7, 32'h5000, 8'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_collect", s_wready, 1);
    rst_n = 1'b0;
    #1;
    check_zero("t6_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    nb = 0;
    repeat (20) begin
      @(negedge clk);
      if (s_bvalid) nb++;
    end
    chk("t6_no_b", 32'(nb), 0);

    burst(4'd9, 32'h6025, 0, -1);
    drain();
    chk("left_chunks", 32'(exp_c.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
